// File: rtl/bnn_neuron_serial.sv
// bnn_neuron_serial: time-multiplexed binary-weight neuron with shift scaling, symmetric saturation and optional ReLU
module bnn_neuron_serial #(
    parameter int WIDTH_IN = 8,
    parameter int LANES    = 16,
    parameter int FAN_IN   = 128,
    localparam int ACC_W   = WIDTH_IN + $clog2(FAN_IN) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH_IN-1:0]  in_act,
    input  logic [LANES-1:0]           in_wgt,
    input  logic [4:0]                 alpha,
    input  logic                       relu_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH_IN-1:0] out_result,
    output logic                       out_sat
);
    localparam int BEATS = FAN_IN / LANES;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic signed [ACC_W-1:0] MAX = ACC_W'((1 << (WIDTH_IN - 1)) - 1);
    localparam logic signed [ACC_W-1:0] NEG_MAX = -MAX;

    if (FAN_IN % LANES != 0) begin : g_fan_in_check
        $error("FAN_IN must be a multiple of LANES");
    end

    typedef enum logic [1:0] {ACCUM, SAT, OUT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [4:0]                 alpha_q, alpha_d;
    logic                       relu_q, relu_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic signed [WIDTH_IN-1:0] result_q, result_d;
    logic                       sat_q, sat_d;
    logic signed [ACC_W-1:0]    term, lane_sum, shifted, clipped;
    logic                       xfer, first, last, clip;

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_sat    = sat_q;
    assign xfer  = in_valid & ready_q;
    assign first = cnt_q == '0;
    assign last  = cnt_q == CNT_W'(BEATS - 1);

    // Signed +/- sum of one beat; terms widened first so negating -2^(W-1) is exact
    always_comb begin
        term     = '0;
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            term     = ACC_W'($signed(in_act[i*WIDTH_IN +: WIDTH_IN]));
            lane_sum = lane_sum + (in_wgt[i] ? term : -term);
        end
    end

    // Scale and clip symmetrically to +/-MAX so the result never reaches -2^(W-1)
    always_comb begin
        shifted = acc_q >>> alpha_q;
        clip    = (shifted > MAX) || (shifted < NEG_MAX);
        clipped = shifted > MAX ? MAX : shifted < NEG_MAX ? NEG_MAX : shifted;
    end

    // Next-state and datapath updates for the ACCUM -> SAT -> OUT sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        alpha_d  = alpha_q;
        relu_d   = relu_q;
        valid_d  = valid_q;
        result_d = result_q;
        sat_d    = sat_q;
        case (state_q)
            ACCUM: if (xfer) begin
                acc_d   = first ? lane_sum : acc_q + lane_sum;
                alpha_d = first ? alpha : alpha_q;
                relu_d  = first ? relu_en : relu_q;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? SAT : ACCUM;
            end
            SAT: begin
                result_d = (relu_q && clipped < 0) ? '0 : WIDTH_IN'(clipped);
                sat_d    = clip;
                valid_d  = 1'b1;
                state_d  = OUT;
            end
            OUT: if (out_ready) begin
                valid_d = 1'b0;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        ready_d = state_d == ACCUM;
    end

    // State and datapath registers; ready stays low through reset and comes up one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            acc_q    <= '0;
            alpha_q  <= '0;
            relu_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            alpha_q  <= alpha_d;
            relu_q   <= relu_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end
endmodule

// File: tb/tb_bnn_neuron_serial.sv
// tb_bnn_neuron_serial: directed-vector bench for the serial binary-weight neuron
module tb_bnn_neuron_serial;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_act;
    logic [15:0]       in_wgt;
    logic [4:0]        alpha;
    logic              relu_en;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_result;
    logic              out_sat;

    bnn_neuron_serial dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
        .in_wgt(in_wgt), .alpha(alpha), .relu_en(relu_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         a0;
        int         a;
        logic [15:0] w;
        int         al;
        bit         relu;
        int         res;
        int         sat;
    } vec_t;

    vec_t              tbl[14];
    logic signed [7:0] va[8][16];
    logic [15:0]       vw[8];
    int                n_chk = 0;
    int                n_err = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic fill(input int a0, input int a, input logic [15:0] w);
        for (int b = 0; b < 8; b++) begin
            vw[b] = w;
            for (int i = 0; i < 16; i++) va[b][i] = (b == 0 && i == 0) ? 8'(a0) : 8'(a);
        end
    endtask

    task automatic model(input int al, input bit rl, output int r, output int s);
        int sum, sh;
        sum = 0;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 16; i++) sum += vw[b][i] ? int'(va[b][i]) : -int'(va[b][i]);
        sh = sum >>> al;
        s  = (sh > 127 || sh < -127) ? 1 : 0;
        r  = sh > 127 ? 127 : sh < -127 ? -127 : sh;
        if (rl && r < 0) r = 0;
    endtask

    task automatic send(input int al, input bit rl, input bit gaps, input int nbeats);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            for (int i = 0; i < 16; i++) in_act[i*8 +: 8] = va[b][i];
            in_wgt   = vw[b];
            alpha    = b == 0 ? 5'(al) : 5'($urandom_range(0, 31));
            relu_en  = b == 0 ? rl : 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) chk("ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input string nm, input int er, input int es);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_result"}, out_result, er);
        chk({nm, "_sat"}, out_sat, es);
        if (out_ready) begin
            @(posedge clk); #1;
            chk({nm, "_valid_drop"}, out_valid, 0);
        end
    endtask

    initial begin
        int er, es, al;
        tbl[0]  = '{"ones",          1,    1,    16'hFFFF, 0,  1'b0, 127,  1};
        tbl[1]  = '{"alternating",   3,    3,    16'h5555, 0,  1'b0, 0,    0};
        tbl[2]  = '{"neg128_a7",     -128, -128, 16'h0000, 7,  1'b0, 127,  1};
        tbl[3]  = '{"neg128_a8",     -128, -128, 16'h0000, 8,  1'b0, 64,   0};
        tbl[4]  = '{"minus5_a1",     5,    0,    16'h0000, 1,  1'b0, -3,   0};
        tbl[5]  = '{"minus5_relu",   5,    0,    16'h0000, 1,  1'b1, 0,    0};
        tbl[6]  = '{"neg_clip",      -1,   -1,   16'hFFFF, 0,  1'b0, -127, 1};
        tbl[7]  = '{"big_alpha_pos", -128, -128, 16'h0000, 20, 1'b0, 0,    0};
        tbl[8]  = '{"big_alpha_neg", 1,    1,    16'h0000, 31, 1'b0, -1,   0};
        tbl[9]  = '{"twos_a3",       2,    2,    16'hFFFF, 3,  1'b0, 32,   0};
        tbl[10] = '{"relu_pos",      100,  0,    16'hFFFF, 0,  1'b1, 100,  0};
        tbl[11] = '{"relu_neg",      -7,   0,    16'hFFFF, 0,  1'b1, 0,    0};
        tbl[12] = '{"edge_pos",      127,  0,    16'hFFFF, 0,  1'b0, 127,  0};
        tbl[13] = '{"edge_neg",      -127, 0,    16'hFFFF, 0,  1'b0, -127, 0};
        rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; alpha = '0; relu_en = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_sat", out_sat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1);
        for (int k = 0; k < 14; k++) begin
            fill(tbl[k].a0, tbl[k].a, tbl[k].w);
            send(tbl[k].al, tbl[k].relu, 1'b0, 8);
            recv(tbl[k].name, tbl[k].res, tbl[k].sat);
        end
        fill(7, 7, 16'hFFFF);
        send(3, 1'b0, 1'b0, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_result", out_result, 0);
        chk("midrst_out_sat", out_sat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill(1, 1, 16'hFFFF);
        send(2, 1'b0, 1'b0, 8);
        recv("after_reset", 32, 0);
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < 8; b++) begin
                vw[b] = 16'($urandom);
                for (int i = 0; i < 16; i++) va[b][i] = 8'($urandom);
            end
            al = $urandom_range(0, 4);
            model(al, 1'b0, er, es);
            out_ready = 1'b0;
            send(al, 1'b0, 1'b1, 8);
            recv("stall", er, es);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_result", out_result, er);
                chk("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("stall_release_valid", out_valid, 0);
            chk("stall_release_ready", in_ready, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
